// File: rtl/muldiv_if.sv
// Request/response bundle between the issue stage, the register file and the
// iterative multiply/divide unit.
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            wr_en;
  logic [4:0]      wr_addr;

  modport master (output start, funct3, rs1_data, rs2_data, rd_in,
                  input  busy, done, result, wr_en, wr_addr);
  modport slave  (input  start, funct3, rs1_data, rs2_data, rd_in,
                  output busy, done, result, wr_en, wr_addr);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, with the sign fix-up applied on the edge entering FIN.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN-1);
  localparam logic [XLEN-1:0]  ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_f3;
  logic [XLEN-1:0]   r_a, r_b, r_result;
  logic [4:0]        r_rd;
  logic              r_sa, r_sb;
  logic [2*XLEN-1:0] r_acc, r_x;
  logic [XLEN-1:0]   r_y, r_quo, r_rem;

  logic              w_s1, w_s2, w_sa, w_sb, w_div0, w_ovf;
  logic [XLEN-1:0]   w_ma, w_mb, w_spec;
  logic [2*XLEN-1:0] w_acc_nxt, w_prod;
  logic [XLEN:0]     w_rsh, w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nxt, w_quo_nxt, w_q, w_r, w_fin;

  // Operand signedness per funct3; MUL stays unsigned since its low half is sign-agnostic.
  always_comb begin
    w_s1 = 1'b0;
    w_s2 = 1'b0;
    case (r_f3)
      3'b001, 3'b100, 3'b110: begin w_s1 = 1'b1; w_s2 = 1'b1; end
      3'b010:                 w_s1 = 1'b1;
      default: ;
    endcase
  end

  assign w_sa   = w_s1 & r_a[XLEN-1];
  assign w_sb   = w_s2 & r_b[XLEN-1];
  assign w_ma   = w_sa ? -r_a : r_a;
  assign w_mb   = w_sb ? -r_b : r_b;
  assign w_div0 = (r_b == '0);
  assign w_ovf  = !r_f3[0] && (r_a == SMIN) && (r_b == ONES);
  assign w_spec = w_div0 ? (r_f3[1] ? r_a : ONES) : (r_f3[1] ? '0 : SMIN);

  // One iteration of each datapath; r_y is the multiplier (shifted) or the divisor (static).
  assign w_acc_nxt = r_y[0] ? r_acc + r_x : r_acc;
  assign w_rsh     = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_rsh - {1'b0, r_y};
  assign w_ge      = !w_diff[XLEN];
  assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

  assign w_prod = (r_sa ^ r_sb) ? -w_acc_nxt : w_acc_nxt;
  assign w_q    = (r_sa ^ r_sb) ? -w_quo_nxt : w_quo_nxt;
  assign w_r    = r_sa ? -w_rem_nxt : w_rem_nxt;

  always_comb begin
    w_fin = w_r;
    case (r_f3)
      3'b000:                 w_fin = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fin = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fin = w_q;
      default:                w_fin = w_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_f3    <= bus.funct3;
          r_a     <= bus.rs1_data;
          r_b     <= bus.rs2_data;
          r_rd    <= bus.rd_in;
          r_state <= S_PREP;
        end
        S_PREP: begin
          r_sa  <= w_sa;
          r_sb  <= w_sb;
          r_acc <= '0;
          r_x   <= {{XLEN{1'b0}}, w_ma};
          r_y   <= w_mb;
          r_quo <= w_ma;
          r_rem <= '0;
          r_cnt <= '0;
          if (r_f3[2] && (w_div0 || w_ovf)) begin
            r_result <= w_spec;
            r_state  <= S_FIN;
          end else begin
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_f3[2]) begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
          end else begin
            r_acc <= w_acc_nxt;
            r_x   <= r_x << 1;
            r_y   <= r_y >> 1;
          end
          if (r_cnt == LAST) begin
            r_result <= w_fin;
            r_state  <= S_FIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_FIN);
  assign bus.result  = r_result;
  assign bus.wr_en   = bus.done && (r_rd != '0);
  assign bus.wr_addr = r_rd;
endmodule
